reduce_tree_pipe: RTL and testbench

//  Parametrised, pipelined N-input bitwise reduction unit: generalises the 4-input OR to N_IN lanes of

---
 rtl/reduce_tree_pipe_pkg.sv | 24 ++
 rtl/reduce_tree_pipe_if.sv | 23 ++
 rtl/reduce_tree_pipe_reduce2_stage.sv | 57 +++++
 rtl/reduce_tree_pipe.sv | 90 +++++++++
 tb/tb_reduce_tree_pipe.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_tree_pipe_pkg.sv
// Shared definitions for the pipelined reduction tree: op encodings, leaf padding identity
// and a constant-evaluable ceil(log2) used to size the tree.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < n; p = p << 1) r++;
        return r;
    endfunction

    // Value of a padded leaf bit that leaves the reduction unchanged.
    function automatic logic identity(input op_e op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Beat-level handshake bundle of reduce_tree_pipe; signal names are from the reducer's side.
interface reduce_tree_pipe_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned WIDTH = 4
);
    logic                    i_valid;
    logic                    o_ready;
    logic [N_IN*WIDTH-1:0]   i_data;
    logic [1:0]              i_op;
    logic                    o_valid;
    logic                    i_ready;
    logic [WIDTH-1:0]        o_f;

    modport slave (
        input  i_valid, i_data, i_op, i_ready,
        output o_ready, o_valid, o_f
    );

    modport master (
        output i_valid, i_data, i_op, i_ready,
        input  o_ready, o_valid, o_f
    );
endinterface

// File: rtl/reduce_tree_pipe_reduce2_stage.sv
// One registered level of the reduction tree: combines adjacent lane pairs under the beat's op
// and carries op/valid alongside. Bubbles still load data so nothing goes X after reset.
module reduce2_stage
    import reduce_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned N_PAIRS = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  op_e                          i_op,
    input  logic [2*N_PAIRS*WIDTH-1:0]   i_data,
    output logic                         o_valid,
    output op_e                          o_op,
    output logic [N_PAIRS*WIDTH-1:0]     o_data
);

    logic                       valid_q;
    op_e                        op_q;
    logic [N_PAIRS*WIDTH-1:0]   data_d, data_q;
    logic [WIDTH-1:0]           a, b;

    // NOR reduces as OR here; the top inverts once after the last level.
    always_comb begin
        data_d = '0;
        a      = '0;
        b      = '0;
        for (int unsigned j = 0; j < N_PAIRS; j++) begin
            a = i_data[2*j*WIDTH +: WIDTH];
            b = i_data[(2*j+1)*WIDTH +: WIDTH];
            unique case (i_op)
                OP_AND:  data_d[j*WIDTH +: WIDTH] = a & b;
                OP_XOR:  data_d[j*WIDTH +: WIDTH] = a ^ b;
                default: data_d[j*WIDTH +: WIDTH] = a | b;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_OR;
            data_q  <= '0;
        end else if (i_en) begin
            valid_q <= i_valid;
            op_q    <= i_op;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_op    = op_q;
    assign o_data  = data_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N_IN-lane bitwise OR/AND/XOR/NOR reducer, one register per tree level.
// Optional sticky result accumulator under `define REDUCE_TREE_STICKY_EN.
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    reduce_tree_pipe_if.slave    bus
`ifdef REDUCE_TREE_STICKY_EN
    ,
    input  logic                 i_sticky_clr,
    output logic [WIDTH-1:0]     o_sticky
`endif
);

    localparam int unsigned LEVELS = clog2(N_IN);
    localparam int unsigned LEAVES = 1 << LEVELS;
    localparam int unsigned NODES  = 2 * LEAVES - 1;

    // Heap-ordered tree: node k has children 2k+1 and 2k+2, root at node 0, lane i at LEAVES-1+i.
    logic [NODES*WIDTH-1:0] tree_data;
    logic [LEVELS:0]        valid_chain;
    op_e                    op_chain [LEVELS+1];
    op_e                    in_op;
    logic                   stall;
    logic                   en;

    assign in_op          = op_e'(bus.i_op);
    assign stall          = bus.o_valid & ~bus.i_ready;
    assign en             = ~stall;
    assign bus.o_ready    = ~stall;
    assign valid_chain[0] = bus.i_valid;
    assign op_chain[0]    = in_op;

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N_IN) begin : g_lane
            assign tree_data[(LEAVES-1+i)*WIDTH +: WIDTH] = bus.i_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign tree_data[(LEAVES-1+i)*WIDTH +: WIDTH] = {WIDTH{identity(in_op)}};
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned NP = LEAVES >> (l + 1);
        reduce2_stage #(
            .WIDTH   (WIDTH),
            .N_PAIRS (NP)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (en),
            .i_valid (valid_chain[l]),
            .i_op    (op_chain[l]),
            .i_data  (tree_data[(2*NP-1)*WIDTH +: 2*NP*WIDTH]),
            .o_valid (valid_chain[l+1]),
            .o_op    (op_chain[l+1]),
            .o_data  (tree_data[(NP-1)*WIDTH +: NP*WIDTH])
        );
    end

    assign bus.o_valid = valid_chain[LEVELS];
    assign bus.o_f     = tree_data[WIDTH-1:0] ^ {WIDTH{op_chain[LEVELS] == OP_NOR}};

`ifdef REDUCE_TREE_STICKY_EN
    logic [WIDTH-1:0] sticky_d, sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (i_sticky_clr) begin
            sticky_d = '0;
        end else if (bus.o_valid && bus.i_ready) begin
            sticky_d = sticky_q | bus.o_f;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench for reduce_tree_pipe: an 8-lane and a 5-lane instance, each with its own
// expected-result queue checked by an output monitor. Sticky checks under REDUCE_TREE_STICKY_EN.
module tb_reduce_tree_pipe;
    import reduce_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reduce_tree_pipe_if #(.N_IN(8), .WIDTH(4)) bus8 ();
    reduce_tree_pipe_if #(.N_IN(5), .WIDTH(4)) bus5 ();

    logic [3:0] exp8_q [$];
    logic [3:0] exp5_q [$];

`ifdef REDUCE_TREE_STICKY_EN
    logic       sticky_clr = 1'b0;
    logic       sticky_clr5 = 1'b0;
    logic [3:0] sticky8, sticky5;
`endif

    reduce_tree_pipe #(.N_IN(8), .WIDTH(4)) u_dut8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus8)
`ifdef REDUCE_TREE_STICKY_EN
        ,
        .i_sticky_clr (sticky_clr),
        .o_sticky     (sticky8)
`endif
    );

    reduce_tree_pipe #(.N_IN(5), .WIDTH(4)) u_dut5 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus5)
`ifdef REDUCE_TREE_STICKY_EN
        ,
        .i_sticky_clr (sticky_clr5),
        .o_sticky     (sticky5)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Output monitors: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus8.o_valid && bus8.i_ready) begin
            if (exp8_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut8_spurious_out actual=%0h expected=no output", bus8.o_f);
            end else begin
                chk("dut8_out", bus8.o_f, exp8_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus5.o_valid && bus5.i_ready) begin
            if (exp5_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut5_spurious_out actual=%0h expected=no output", bus5.o_f);
            end else begin
                chk("dut5_out", bus5.o_f, exp5_q.pop_front());
            end
        end
    end

    // Presents a beat and returns one unit after the edge that accepted it, i_valid left high.
    task automatic send8(input logic [31:0] d, input logic [1:0] op, input logic [3:0] e,
                         input bit track);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus8.i_valid = 1'b1;
        bus8.i_data  = d;
        bus8.i_op    = op;
        if (track) exp8_q.push_back(e);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus8.o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("dut8_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic idle8();
        bus8.i_valid = 1'b0;
        bus8.i_data  = '0;
        bus8.i_op    = 2'b00;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (exp8_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("dut8_drain_left", exp8_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send5(input logic [19:0] d, input logic [1:0] op, input logic [3:0] e);
        bus5.i_valid = 1'b1;
        bus5.i_data  = d;
        bus5.i_op    = op;
        exp5_q.push_back(e);
        @(negedge clk);
        chk("dut5_ready", {31'b0, bus5.o_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus5.i_valid = 1'b0;
        bus5.i_data  = '0;
        bus5.i_op    = 2'b00;
    endtask

    task automatic drain5();
        int n;
        n = 0;
        while (exp5_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("dut5_drain_left", exp5_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  vals [6];
        logic [31:0] d;
        logic [3:0]  f0;
        int          n;

        vals = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
        bus8.i_valid = 1'b0; bus8.i_data = '0; bus8.i_op = 2'b00; bus8.i_ready = 1'b1;
        bus5.i_valid = 1'b0; bus5.i_data = '0; bus5.i_op = 2'b00; bus5.i_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", {31'b0, bus8.o_valid}, 32'd0);
        chk("rst_o_f", bus8.o_f, 32'd0);
        chk("rst_o_ready", {31'b0, bus8.o_ready}, 32'd1);
        chk("rst_o_valid5", {31'b0, bus5.o_valid}, 32'd0);
`ifdef REDUCE_TREE_STICKY_EN
        chk("rst_sticky", sticky8, 32'd0);
`endif
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with three beats in flight: all must vanish
        send8(32'h1111_1111, OP_OR, 4'h0, 1'b0);
        send8(32'h2222_2222, OP_OR, 4'h0, 1'b0);
        send8(32'h4444_4444, OP_OR, 4'h0, 1'b0);
        idle8();
        rst_n = 1'b0;
        #1;
        chk("t1_rst_o_valid", {31'b0, bus8.o_valid}, 32'd0);
        chk("t1_rst_o_f", bus8.o_f, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_no_output", {31'b0, bus8.o_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // OR with a single bit in lane 5; o_valid exactly three cycles after the beat
        send8(32'h0020_0000, OP_OR, 4'h2, 1'b1);
        idle8();
        @(negedge clk);
        chk("t2_lat_c1", {31'b0, bus8.o_valid}, 32'd0);
        @(negedge clk);
        chk("t2_lat_c2", {31'b0, bus8.o_valid}, 32'd0);
        @(negedge clk);
        chk("t2_lat_c3", {31'b0, bus8.o_valid}, 32'd1);
        drain8();

        // Mixed ops back to back, results on consecutive cycles
        send8(32'hFFFF_FFFE, OP_AND, 4'hE, 1'b1);
        send8(32'h0000_1110, OP_XOR, 4'h1, 1'b1);
        send8(32'h0000_0000, OP_NOR, 4'hF, 1'b1);
        idle8();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_consecutive", {31'b0, bus8.o_valid}, 32'd1);
        end
        @(negedge clk);
        chk("t3_gap_after", {31'b0, bus8.o_valid}, 32'd0);
        drain8();

        // Backpressure: six beats, output held off for four cycles once valid
        bus8.i_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    d = {28'b0, vals[k]} << (4 * k);
                    send8(d, OP_OR, vals[k], 1'b1);
                end
                idle8();
            end
            begin
                n = 0;
                @(negedge clk);
                while (!bus8.o_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("t4_valid_rise", {31'b0, bus8.o_valid}, 32'd1);
                f0 = bus8.o_f;
                for (int i = 0; i < 4; i++) begin
                    chk("t4_hold_o_ready", {31'b0, bus8.o_ready}, 32'd0);
                    chk("t4_hold_o_f", bus8.o_f, f0);
                    @(posedge clk);
                    #1;
                    if (i < 3) @(negedge clk);
                end
                bus8.i_ready = 1'b1;
            end
        join
        drain8();

        // Five lanes: padded leaves must be neutral for every op
        send5(20'hFFFFF, OP_AND, 4'hF);
        @(negedge clk);
        chk("t5_lat_c1", {31'b0, bus5.o_valid}, 32'd0);
        @(negedge clk);
        chk("t5_lat_c2", {31'b0, bus5.o_valid}, 32'd0);
        @(negedge clk);
        chk("t5_lat_c3", {31'b0, bus5.o_valid}, 32'd1);
        drain5();
        send5(20'h00000, OP_OR, 4'h0);
        send5(20'h11111, OP_XOR, 4'h1);
        send5(20'h00000, OP_NOR, 4'hF);
        drain5();

`ifdef REDUCE_TREE_STICKY_EN
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("t6_sticky_cleared", sticky8, 32'd0);
        send8(32'h0000_0001, OP_OR, 4'h1, 1'b1);
        send8(32'h0000_0008, OP_OR, 4'h8, 1'b1);
        idle8();
        drain8();
        chk("t6_sticky_accum", sticky8, 32'h9);
        send8(32'h0000_0002, OP_OR, 4'h2, 1'b1);
        idle8();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_handshake_valid", {31'b0, bus8.o_valid}, 32'd1);
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("t6_clear_wins", sticky8, 32'd0);
        drain8();
`endif

        chk("final_exp8_empty", exp8_q.size(), 32'd0);
        chk("final_exp5_empty", exp5_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
